uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
UART receiver, 8N1, LSB first. It is the receive-direction counterpart of uart_tx. It oversamples rx_serial on clk with a per-bit cycle counter and samples each bit at its centre. Each valid byte is pushed into a write-side FIFO as a one-cycle write strobe, gated by the FIFO full flag. Framing errors and FIFO overruns are reported as one-cycle pulses.

Parameters:
CLKS_PER_BIT, 87, clk cycles per UART bit (e.g. 10 MHz / 115200); legal range >= 4.
DATA_BITS, 8, data bits per frame; fixed at 8 for this revision.

Ports:
clk  input  1  receiver clock, rising edge.
areset  input  1  asynchronous, active-high reset.
rx_serial  input  1  asynchronous serial line; idles high.
full  input  1  full flag from downstream FIFO write side.
data  output  8  last accepted byte; stable between WE pulses.
WE  output  1  one-cycle write strobe to FIFO; data is valid while WE=1.
frame_err  output  1  one-cycle pulse when the stop bit samples low.
overrun  output  1  one-cycle pulse when a good byte is dropped because full=1.

Behaviour:
- Reset (async, areset=1): state=IDLE; both synchronizer flops=1; bit counter=0; bit index=0; shift register=0; data=0x00; WE=0; frame_err=0; overrun=0.
- rx_serial passes through a 2-flop synchronizer; rx_s denotes its output. The FSM sees only rx_s, which lags rx_serial by 2 clk cycles.
- Cycle counter width is $clog2(CLKS_PER_BIT). HALF=(CLKS_PER_BIT-1)/2 (integer division).
- IDLE: counter=0, index=0. rx_s=0 -> START.
- START: counter increments each cycle. When counter==HALF:
  - rx_s=0 -> DATA, counter=0.
  - rx_s=1 -> IDLE. This is glitch rejection; no outputs change.
- DATA: counter increments each cycle. When counter==CLKS_PER_BIT-1:
  - Sample rx_s into the shift register MSB and shift right (LSB-first reassembly).
  - Counter=0, index+1. After the 8th sample (index==7) -> STOP.
- STOP: when counter==CLKS_PER_BIT-1, sample rx_s:
  - rx_s=1 and full=0: data<=shift register, WE=1 for exactly one cycle -> IDLE.
  - rx_s=1 and full=1: overrun=1 for one cycle; data unchanged; WE stays 0 -> IDLE.
  - rx_s=0: frame_err=1 for one cycle; data unchanged; WE stays 0 -> BREAK.
- BREAK: wait for rx_s=1, then -> IDLE. A held-low line therefore produces exactly one frame_err.
- WE, frame_err and overrun are registered and mutually exclusive. Each is high for at most one cycle per frame.
- full is sampled only in the STOP sample cycle. Its value during the frame is ignored.
- Latency: the WE rising edge occurs 2 + HALF + 1 + 9*CLKS_PER_BIT + 1 cycles (±1) after the rx_serial falling edge.
- A start edge is accepted on the first cycle after the STOP sample, which allows back-to-back frames with a single stop bit.
- areset asserted mid-frame aborts the frame immediately. No WE, frame_err or overrun is emitted for that frame. The next start edge after release is received normally.

Decomposition:
- Package uart_pkg holds:
  - state enum {IDLE, START, DATA, STOP, BREAK};
  - the default CLKS_PER_BIT constant, shared with uart_tx so both ends agree on baud;
  - DATA_BITS=8.
- One sub-module, sync_2ff: a 2-flop synchronizer with parameterised reset value, reset to 1 here, on async active-high reset. It is reusable for other asynchronous inputs.

Test Plan:
1. CLKS_PER_BIT=16. Drive frame 0xA5 (start, bits 1,0,1,0,0,1,0,1 LSB first, stop=1), full=0 -> single WE pulse with data=0xA5 at latency 2+7+1+144+1 ±1 cycles; frame_err=0, overrun=0.
2. rx_serial low for 4 cycles, then high -> FSM returns to IDLE; no WE, frame_err or overrun; a following 0x3C frame is received correctly as data=0x3C.
3. Frame 0x5A with stop bit=0, then line held low for 20 bit-times -> exactly one frame_err pulse and no WE; data keeps its previous value. Line returns high, then frame 0x11 -> WE with data=0x11.
4. full=1 during the stop-bit sample of frame 0x55 -> one overrun pulse, no WE, data unchanged. Next frame 0x66 with full=0 -> WE with data=0x66.
5. Back-to-back frames 0x00, 0xFF, 0x80 with one stop bit each and no idle gap -> three WE pulses, with data=0x00, 0xFF, 0x80 in order.
6. Assert areset during bit 4 of frame 0xC3 -> all outputs are 0 within the same cycle and the state is IDLE. Release, then send frame 0x7E -> WE with data=0x7E and no spurious pulses.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared UART constants and receiver state type
package uart_pkg;

  // Shared with uart_tx so both ends agree on the baud divisor.
  localparam int DEFAULT_CLKS_PER_BIT = 87;
  localparam int UART_DATA_BITS       = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_e;

endpackage

// File: rtl/uart_rx_if.sv
// rtl/uart_rx_if.sv - receiver-to-FIFO write side plus error pulses
interface uart_rx_if;
  logic       full;
  logic [7:0] data;
  logic       WE;
  logic       frame_err;
  logic       overrun;

  modport master (input full, output data, output WE, output frame_err, output overrun);
  modport slave  (output full, input data, input WE, input frame_err, input overrun);
endinterface

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer with selectable reset value
module sync_2ff #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;
endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 UART receiver, centre-sampled, pushes bytes into a FIFO
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int DATA_BITS    = UART_DATA_BITS
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       rx_serial,
  uart_rx_if.master  fifo
);
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam int IW   = $clog2(DATA_BITS);
  localparam int HALF = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_BITS - 1);

  logic rx_s;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 we_q, we_d;
  logic                 fe_q, fe_d;
  logic                 ov_q, ov_d;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (areset),
    .d_i (rx_serial),
    .q_o (rx_s)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      fe_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      we_q    <= we_d;
      fe_q    <= fe_d;
      ov_q    <= ov_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    we_d    = 1'b0;
    fe_d    = 1'b0;
    ov_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Re-check the line mid start bit so short glitches are dropped.
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end else begin
            state_d = IDLE;
            if (fifo.full) begin
              ov_d = 1'b1;
            end else begin
              data_d = shift_q;
              we_d   = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      BREAK: begin
        // A held-low line reports one framing error, then waits for idle.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign fifo.data      = data_q;
  assign fifo.WE        = we_q;
  assign fifo.frame_err = fe_q;
  assign fifo.overrun   = ov_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - directed self-checking bench for uart_rx
module tb_uart_rx;
  import uart_pkg::*;

  localparam int CPB = 16;

  logic clk       = 1'b0;
  logic areset    = 1'b1;
  logic rx_serial = 1'b1;

  uart_rx_if fifo_if ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk       (clk),
    .areset    (areset),
    .rx_serial (rx_serial),
    .fifo      (fifo_if)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int we_cnt = 0, fe_cnt = 0, ov_cnt = 0, we_cyc = 0;
  logic [7:0] we_log[$];

  always @(negedge clk) begin
    if (fifo_if.WE) begin
      we_cnt = we_cnt + 1;
      we_cyc = cyc;
      we_log.push_back(fifo_if.data);
    end
    if (fifo_if.frame_err) fe_cnt = fe_cnt + 1;
    if (fifo_if.overrun)   ov_cnt = ov_cnt + 1;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int fall_cyc = 0;
  int we0, fe0, ov0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic full_at_stop);
    fall_cyc  = cyc;
    rx_serial = 1'b0;
    hold(CPB);
    for (int i = 0; i < 8; i++) begin
      rx_serial = b[i];
      hold(CPB);
    end
    fifo_if.full = full_at_stop;
    rx_serial    = stop_bit;
    hold(CPB);
    fifo_if.full = 1'b0;
  endtask

  task automatic snap();
    we0 = we_cnt;
    fe0 = fe_cnt;
    ov0 = ov_cnt;
  endtask

  initial begin
    fifo_if.full = 1'b0;
    hold(3);
    chk("rst_data",  32'(fifo_if.data), 32'h00);
    chk("rst_we",    32'(fifo_if.WE), 32'd0);
    chk("rst_fe",    32'(fifo_if.frame_err), 32'd0);
    chk("rst_ov",    32'(fifo_if.overrun), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    areset = 1'b0;
    hold(2 * CPB);

    // 1: single frame 0xA5, latency 2+7+1+144+1 = 155 (+/-1)
    snap();
    send_frame(8'hA5, 1'b1, 1'b0);
    hold(CPB);
    chk("t1_we_count", 32'(we_cnt - we0), 32'd1);
    chk("t1_data",     32'(fifo_if.data), 32'hA5);
    chk("t1_latency",  32'((we_cyc - fall_cyc >= 154) && (we_cyc - fall_cyc <= 156)), 32'd1);
    chk("t1_fe",       32'(fe_cnt - fe0), 32'd0);
    chk("t1_ov",       32'(ov_cnt - ov0), 32'd0);

    // 2: 4-cycle glitch is rejected, then 0x3C
    snap();
    rx_serial = 1'b0;
    hold(4);
    rx_serial = 1'b1;
    hold(3 * CPB);
    chk("t2_glitch_state", 32'(dut.state_q), 32'(IDLE));
    chk("t2_glitch_none",  32'((we_cnt - we0) + (fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
    send_frame(8'h3C, 1'b1, 1'b0);
    hold(CPB);
    chk("t2_we_count", 32'(we_cnt - we0), 32'd1);
    chk("t2_data",     32'(fifo_if.data), 32'h3C);

    // 3: bad stop bit on 0x5A, line held low 20 bit-times, then 0x11
    snap();
    send_frame(8'h5A, 1'b0, 1'b0);
    rx_serial = 1'b0;
    hold(20 * CPB);
    chk("t3_fe_count", 32'(fe_cnt - fe0), 32'd1);
    chk("t3_no_we",    32'(we_cnt - we0), 32'd0);
    chk("t3_data_kept", 32'(fifo_if.data), 32'h3C);
    chk("t3_state_brk", 32'(dut.state_q), 32'(BREAK));
    rx_serial = 1'b1;
    hold(2 * CPB);
    send_frame(8'h11, 1'b1, 1'b0);
    hold(CPB);
    chk("t3_we_after", 32'(we_cnt - we0), 32'd1);
    chk("t3_data_11",  32'(fifo_if.data), 32'h11);

    // 4: full at stop sample of 0x55 -> overrun, then 0x66
    snap();
    send_frame(8'h55, 1'b1, 1'b1);
    hold(CPB);
    chk("t4_ov_count", 32'(ov_cnt - ov0), 32'd1);
    chk("t4_no_we",    32'(we_cnt - we0), 32'd0);
    chk("t4_no_fe",    32'(fe_cnt - fe0), 32'd0);
    chk("t4_data_kept", 32'(fifo_if.data), 32'h11);
    send_frame(8'h66, 1'b1, 1'b0);
    hold(CPB);
    chk("t4_we_after", 32'(we_cnt - we0), 32'd1);
    chk("t4_data_66",  32'(fifo_if.data), 32'h66);

    // 5: back-to-back 0x00, 0xFF, 0x80 with no idle gap
    snap();
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    send_frame(8'h80, 1'b1, 1'b0);
    hold(CPB);
    chk("t5_we_count", 32'(we_cnt - we0), 32'd3);
    if (we_log.size() >= 3) begin
      chk("t5_byte0", 32'(we_log[we_log.size()-3]), 32'h00);
      chk("t5_byte1", 32'(we_log[we_log.size()-2]), 32'hFF);
      chk("t5_byte2", 32'(we_log[we_log.size()-1]), 32'h80);
    end else begin
      chk("t5_log_size", 32'(we_log.size()), 32'd3);
    end
    chk("t5_no_err", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

    // 6: reset during bit 4 of 0xC3 (bits LSB first: 1,1,0,0,0,0,1,1)
    snap();
    rx_serial = 1'b0;
    hold(CPB);
    rx_serial = 1'b1; hold(CPB);
    rx_serial = 1'b1; hold(CPB);
    rx_serial = 1'b0; hold(CPB);
    rx_serial = 1'b0; hold(CPB);
    rx_serial = 1'b0; hold(CPB / 2);
    chk("t6_pre_state", 32'(dut.state_q), 32'(DATA));
    areset = 1'b1;
    #1;
    chk("t6_rst_data",  32'(fifo_if.data), 32'h00);
    chk("t6_rst_we",    32'(fifo_if.WE), 32'd0);
    chk("t6_rst_fe",    32'(fifo_if.frame_err), 32'd0);
    chk("t6_rst_ov",    32'(fifo_if.overrun), 32'd0);
    chk("t6_rst_state", 32'(dut.state_q), 32'(IDLE));
    hold(2);
    rx_serial = 1'b1;
    hold(2);
    areset = 1'b0;
    hold(2 * CPB);
    send_frame(8'h7E, 1'b1, 1'b0);
    hold(CPB);
    chk("t6_we_count", 32'(we_cnt - we0), 32'd1);
    chk("t6_data_7e",  32'(fifo_if.data), 32'h7E);
    chk("t6_no_err",   32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
